// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl
//   Wide add/subtract built from one 4-bit slice that is reused once per clock.
//   Nibbles are processed LSB first, and the carry is chained between them.
//   A W-bit operation takes NIBBLES cycles in RUN plus one DONE cycle.
//
// Parameters
//   NIBBLES   operand width in nibbles (W = 4*NIBBLES), 2..16
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   start         request, accepted only in IDLE or DONE
//   subtract      0: a+b, 1: a-b (latched with start)
//   a, b          W-bit operands (latched with start)
//   busy          high while nibbles are being processed
//   done          one-cycle pulse; result/cout/overflow are valid from this cycle
//   result        registered W-bit result, held until the next done
//   cout          final carry out (for subtract, 1 = no borrow)
//   overflow      signed two's-complement overflow
//
// Build option
//   SATURATE_EN   when defined, unsigned saturation is applied to result
//                 (cout and overflow stay raw)

module nibble_serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 subtract,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 overflow
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [W-1:0]     a_q, b_q, acc;
    logic             sub_q, carry;
    logic [IDX_W-1:0] idx;

    logic             take, last;
    logic [3:0]       bx;
    logic [4:0]       sum5;
    logic [W-1:0]     raw_res, res_wr;

    assign take = start && (state == IDLE || state == DONE);
    assign last = (idx == IDX_W'(NIBBLES - 1));

    // The operand registers shift right, so the current nibble is always in bits [3:0].
    // The +1 for subtract enters only through the initial carry.
    assign bx   = b_q[3:0] ^ {4{sub_q}};
    assign sum5 = {1'b0, a_q[3:0]} + {1'b0, bx} + {4'b0, carry};

    // The accumulator fills from the top. After the last nibble, nibble 0 sits at the bottom.
    assign raw_res = {sum5[3:0], acc[W-1:4]};

`ifdef SATURATE_EN
    always_comb begin
        res_wr = raw_res;
        if (!sub_q && sum5[4])
            res_wr = '1;
        else if (sub_q && !sum5[4])
            res_wr = '0;
    end
`else
    assign res_wr = raw_res;
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            sub_q    <= 1'b0;
            carry    <= 1'b0;
            idx      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (take) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= subtract;
            carry <= subtract;
            idx   <= '0;
        end else if (state == RUN) begin
            a_q   <= a_q >> 4;
            b_q   <= b_q >> 4;
            acc   <= raw_res;
            carry <= sum5[4];
            idx   <= idx + 1'b1;
            if (last) begin
                result   <= res_wr;
                cout     <= sum5[4];
                // The carry into the MSB bit is recovered from the sum bit:
                // c3 = a3 ^ b3 ^ s3.
                overflow <= a_q[3] ^ bx[3] ^ sum5[3] ^ sum5[4];
            end
        end
    end

endmodule

// File: doc/nibble_serial_addsub_ctrl.md
Name: nibble_serial_addsub_ctrl

Overview:
Sequencer that performs wide add/subtract by time-multiplexing a single 4-bit add/subtract slice, one nibble per clock, LSB nibble first, with carry/borrow chained between nibbles.
Accepts a start request and latches both operands. Steps through NIBBLES nibbles, then presents the full-width result with carry and signed-overflow flags and a one-cycle done pulse.
Sits between the control path and the 4-bit adder/subtractor datapath, so wide arithmetic costs one nibble slice instead of a full-width adder.

Parameters:
NIBBLES, 4, operand width in nibbles (W = 4*NIBBLES bits); legal range 2..16

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
subtract  input  1  0 = A+B, 1 = A-B; latched with start
a  input  W  operand A; latched with start
b  input  W  operand B; latched with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result/cout/overflow valid from this cycle
result  output  W  registered result; holds until the next done
cout  output  1  final carry out of MSB nibble; for subtract, 1 = no borrow
overflow  output  1  signed two's-complement overflow of the W-bit operation

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0, cout=0, overflow=0.
  - Internal operand/shift regs, nibble index and carry cleared.
- States:
  - IDLE: start=1 -> RUN. Latch a, b, subtract; idx=0; carry=subtract.
  - RUN: each edge processes nibble idx: sum5 = A[idx] + (B[idx] XOR {4{sub}}) + carry. Nibble = sum5[3:0] stored at result position idx in an internal accumulator; carry <= sum5[4]; idx++.
  - RUN, after nibble NIBBLES-1: on the same edge, write the accumulator into result, cout=final carry, overflow=(carry into MSB bit) XOR (carry out of MSB bit); -> DONE.
  - DONE: done=1 for exactly this cycle. start=1 -> RUN with new operands (back-to-back), else -> IDLE.
- Latency:
  - start sampled at edge t; busy=1 from t to t+NIBBLES.
  - done=1 and outputs valid in the cycle after edge t+NIBBLES.
  - Back-to-back throughput: one operation per NIBBLES+1 cycles.
- start while in RUN: ignored; a, b, subtract changes in RUN have no effect.
- Outputs result/cout/overflow change only on the edge entering DONE or on reset.
- Subtract is A + ~B + 1 across the full width, with the +1 injected as the initial carry, never per nibble.
- Arithmetic is modulo 2^W; no exceptions.
- rst_n asserted mid-RUN: abort immediately, all outputs to reset values, no done pulse.
- Operation after reset release: none until a fresh start.

Optional Feature:
Macro SATURATE_EN.
- Defined: unsigned saturation applied at result write.
  - Add with cout=1 -> result = all ones.
  - Subtract with cout=0 (borrow) -> result = 0.
  - cout and overflow still report the raw unsaturated flags.
- Undefined: wrap-around result only. No saturation logic is present.

Test Plan:
1. NIBBLES=4, a=0x1234, b=0x0FFF, subtract=0, pulse start -> busy high 4 cycles, then done=1 for one cycle with result=0x2233, cout=0, overflow=0.
2. a=0x0005, b=0x0007, subtract=1 -> result=0xFFFE, cout=0, overflow=0; with SATURATE_EN: result=0x0000, cout=0.
3. a=0xFFFF, b=0x0001, add -> result=0x0000, cout=1, overflow=0; with SATURATE_EN: result=0xFFFF. Also a=0x7FFF, b=0x0001, add -> result=0x8000, cout=0, overflow=1.
4. a=0x8000, b=0x0001, subtract=1 -> result=0x7FFF, cout=1, overflow=1.
5. Start op (0x1111+0x2222), pulse start with a=0xAAAA two cycles later, and change a/b mid-RUN -> first result=0x3333; the second start is ignored; exactly one done pulse. Then assert start in the DONE cycle with 0x0001+0x0001 -> second done one NIBBLES+1-cycle period later with result=0x0002.
6. Assert rst_n=0 asynchronously during RUN nibble 2 -> busy, done, result, cout, overflow go to 0 immediately. No done pulse follows. The next start completes normally with the correct result.
